priority_scan_encoder: RTL
==========================

Name: priority_scan_encoder

Overview:
- Parametrised, registered successor of the combinational 8:3 priority encoder.
- Accepts an N-bit request vector and emits the index of every set bit, one index per handshake, in priority order (highest index first by default).
- Sits between request/interrupt-style vectors and single-index consumers such as a decoder, mux select or FIFO. All handshakes are valid/ready.

Parameters:
- N, 8: request vector width; legal range 1..256.
- W, max(1,$clog2(N)): index width; derived, must not be overridden.
- LOW_FIRST, 0: 0 = highest set index first (8:3 priority order); 1 = lowest set index first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_vec is offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  N  request vector.
- out_valid  out  1  out_idx/out_last are valid.
- out_ready  in  1  consumer accepts the current index.
- out_idx  out  W  index of the current selected bit.
- out_last  out  1  current index is the final set bit of the vector.
- busy  out  1  a vector is being scanned.

Behaviour:
- One clock, rst_n. Reset is asynchronous, active-low.
- Reset values: state=IDLE, internal pending vector=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0.
- Reset asserted mid-scan abandons the vector immediately; no further indices are emitted.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid & in_ready with in_vec!=0: register in_vec as pending; go to SCAN.
  - On in_valid & in_ready with in_vec==0: accept and discard; stay in IDLE; no output.
- Latency: the first out_valid is asserted on the cycle after acceptance.
- Registered outputs: out_idx and out_last are registers computed from pending. All outputs are glitch-free.
- SCAN:
  - in_ready=0, busy=1, out_valid=1.
  - out_idx = highest set index of pending (LOW_FIRST=0) or lowest set index (LOW_FIRST=1).
  - out_last=1 when pending has exactly one bit set.
- Index transfer on out_valid & out_ready:
  - Clear the bit at out_idx in pending.
  - If out_last=1, go to IDLE next cycle, with in_ready=1 on that cycle.
  - Otherwise out_idx/out_last update to the next index on the next cycle.
- Backpressure: while out_valid & !out_ready, out_idx, out_last and pending hold stable.
- in_valid during SCAN is ignored; the upstream must hold the vector until in_ready.
- Throughput:
  - One index per cycle when out_ready is held high.
  - A K-bit vector occupies K cycles of SCAN plus 1 IDLE cycle before the next acceptance.
- N=1: W=1; out_idx is always 0; out_last is always 1 in SCAN.
- Indices >= N are never produced.
- For N not a power of two, unused out_idx codes never appear.

Test Plan:
- Reset: rst_n=0 asynchronously mid-SCAN with N=8, in_vec=8'b1010_0110 -> same cycle out_valid=0, busy=0, in_ready=1; no further indices after release.
- Priority order: N=8, LOW_FIRST=0, in_vec=8'b1010_0110, out_ready=1 -> out_idx 7,5,2,1 on consecutive cycles; out_last=1 only with idx 1; in_ready=1 on the following cycle.
- LOW_FIRST=1, same vector -> out_idx 1,2,5,7; out_last with 7.
- Single/zero/all-ones:
  - in_vec=8'b0000_0001 -> one transfer, idx 0, out_last=1.
  - in_vec=0 -> accepted, no out_valid, in_ready stays 1.
  - in_vec=8'hFF -> 8 indices 7..0.
- Backpressure: in_vec=8'b1000_0001, out_ready low for 3 cycles then high -> out_idx=7 held stable for 4 cycles, then idx 0 with out_last=1. A second in_valid during SCAN is not accepted (in_ready=0).
- Non-power-of-two: N=5, W=3, in_vec=5'b10011 -> idx 4,1,0. Random 1000-vector run against a reference model: exact index sequence, never idx>=N.

Source files
------------

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder: accepts an N-bit request vector and emits the
// index of every set bit, one per valid/ready transfer, in priority order.
module priority_scan_encoder #(
    parameter int N         = 8,
    parameter int W         = (N > 1) ? $clog2(N) : 1,
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         busy,
    output logic         o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; a valid side holds its payload stable until that transfer.
    typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

    state_t       r_state;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic         r_last;
    logic         r_out_valid;
    logic         r_in_ready;
    logic         r_busy;

    logic [N-1:0] w_remain;
    logic [N-1:0] w_src;
    logic [W-1:0] w_pick;
    logic         w_pick_last;

    // One selector serves both the accept path (fresh vector) and the advance path
    // (pending vector with the current index removed).
    always_comb begin
        w_remain = r_pending;
        for (int i = 0; i < N; i++) begin
            if (W'(i) == r_idx) begin
                w_remain[i] = 1'b0;
            end
        end
        w_src = (r_state == ST_SCAN) ? w_remain : in_vec;
        w_pick = '0;
        if (LOW_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w_src[i]) w_pick = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_src[i]) w_pick = W'(i);
            end
        end
        w_pick_last = (w_src != '0) && ((w_src & (w_src - N'(1))) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // An all-zero vector is accepted and dropped without output.
                    if (in_valid && (in_vec != '0)) begin
                        r_state     <= ST_SCAN;
                        r_pending   <= in_vec;
                        r_idx       <= w_pick;
                        r_last      <= w_pick_last;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_state     <= ST_IDLE;
                            r_pending   <= '0;
                            r_idx       <= '0;
                            r_last      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_pending <= w_remain;
                            r_idx     <= w_pick;
                            r_last    <= w_pick_last;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_idx     = r_idx;
    assign out_last    = r_last;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
